// File: rtl/mbs_escalonador_pkg.sv
// Shared types and defaults for the round-robin scheduler in front of one mbs multiplier.
package mbs_escalonador_pkg;

  localparam int unsigned LARGURA_PADRAO  = 8;
  localparam int unsigned LATENCIA_PADRAO = LARGURA_PADRAO + 1;

  typedef enum logic [2:0] {
    OCIOSO,
    PARTIDA,
    ESPERA,
    CAPTURA,
    ENTREGA
  } estado_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mbs_rr_arbitro.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping mod N_REQ.
module mbs_rr_arbitro #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   idx
);

  logic           achou;
  logic [IDW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    achou = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IDW'((32'(ptr) + k) % N_REQ);
      if (!achou && req[cand]) begin
        achou       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/mbs_escalonador.sv
// Round-robin scheduler sharing one sequential mbs multiplier among N_REQ requesters.
// Define MBS_ESCALONADOR_STATS_EN to add the cont_ops / cont_bloqueio statistics outputs.
module mbs_escalonador
  import mbs_escalonador_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned LARGURA  = LARGURA_PADRAO,
  parameter int unsigned LATENCIA = LARGURA + 1,
  localparam int unsigned IDW     = id_width(N_REQ)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*LARGURA-1:0]   req_a,
  input  logic [N_REQ*LARGURA-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IDW-1:0]             resp_id,
  output logic [2*LARGURA-1:0]       resp_produto,
  output logic                       mult_start,
  output logic [LARGURA-1:0]         mult_multiplicando,
  output logic [LARGURA-1:0]         mult_multiplicador,
  input  logic [2*LARGURA-1:0]       mult_produto,
  output logic                       ocupado
`ifdef MBS_ESCALONADOR_STATS_EN
  ,
  output logic [31:0]                cont_ops,
  output logic [31:0]                cont_bloqueio
`endif
);

  localparam int unsigned    CW       = (LATENCIA < 2) ? 1 : $clog2(LATENCIA);
  localparam logic [CW-1:0]  CONT_INI = CW'(LATENCIA - 1);
  localparam logic [IDW-1:0] ULTIMO   = IDW'(N_REQ - 1);

  estado_t              estado_q, estado_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [LARGURA-1:0]   a_q, a_d, b_q, b_d;
  logic [LARGURA-1:0]   a_sel, b_sel;
  logic [CW-1:0]        cont_q, cont_d;
  logic [2*LARGURA-1:0] prod_q, prod_d;
  logic [N_REQ-1:0]     grant;
  logic [IDW-1:0]       idx;

  mbs_rr_arbitro #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arbitro (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (idx)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        a_sel = req_a[i*LARGURA +: LARGURA];
        b_sel = req_b[i*LARGURA +: LARGURA];
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    cont_d   = cont_q;
    prod_d   = prod_q;
    unique case (estado_q)
      OCIOSO: begin
        if (|req_valid) begin
          estado_d = PARTIDA;
          id_d     = idx;
          a_d      = a_sel;
          b_d      = b_sel;
          ptr_d    = (idx == ULTIMO) ? '0 : idx + 1'b1;
        end
      end
      PARTIDA: begin
        cont_d   = CONT_INI;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (cont_q == '0) estado_d = CAPTURA;
        else              cont_d   = cont_q - 1'b1;
      end
      CAPTURA: begin
        prod_d   = mult_produto;
        estado_d = ENTREGA;
      end
      ENTREGA: begin
        if (resp_ready) estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      ptr_q    <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cont_q   <= '0;
      prod_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cont_q   <= cont_d;
      prod_q   <= prod_d;
    end
  end

  // Grant is gated by reset_n so a held request cannot see req_ready during reset.
  assign req_ready          = (estado_q == OCIOSO && reset_n) ? grant : '0;
  assign mult_start         = (estado_q == PARTIDA);
  assign resp_valid         = (estado_q == ENTREGA);
  assign ocupado            = (estado_q != OCIOSO);
  assign resp_id            = id_q;
  assign resp_produto       = prod_q;
  assign mult_multiplicando = a_q;
  assign mult_multiplicador = b_q;

`ifdef MBS_ESCALONADOR_STATS_EN
  logic [31:0] ops_q, bloq_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ops_q  <= '0;
      bloq_q <= '0;
    end else begin
      if (resp_valid && resp_ready && ops_q != 32'hFFFF_FFFF) ops_q <= ops_q + 1'b1;
      if (|req_valid && ocupado && bloq_q != 32'hFFFF_FFFF) bloq_q <= bloq_q + 1'b1;
    end
  end

  assign cont_ops      = ops_q;
  assign cont_bloqueio = bloq_q;
`endif

endmodule

// File: tb/tb_mbs_escalonador.sv
// Bench for mbs_escalonador with a cycle-accurate mbs stand-in; scoreboard of expected responses.
module tb_mbs_escalonador;
  import mbs_escalonador_pkg::*;

  localparam int unsigned NR  = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned PW  = 2 * W;
  localparam int unsigned LAT = W + 1;
  localparam int unsigned IDW = id_width(NR);

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid, req_ready;
  logic [NR*W-1:0] req_a, req_b;
  logic            resp_valid, resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [PW-1:0]   resp_produto, mult_produto;
  logic            mult_start, ocupado;
  logic [W-1:0]    mult_multiplicando, mult_multiplicador;
`ifdef MBS_ESCALONADOR_STATS_EN
  logic [31:0]     cont_ops, cont_bloqueio;
`endif

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [PW-1:0]  prod;
  } resp_t;

  resp_t sb[$];
  int    grants[$];
  resp_t esp_r;
  int    checks = 0;
  int    erros  = 0;

  mbs_escalonador #(
    .N_REQ    (NR),
    .LARGURA  (W),
    .LATENCIA (LAT)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_a              (req_a),
    .req_b              (req_b),
    .resp_valid         (resp_valid),
    .resp_ready         (resp_ready),
    .resp_id            (resp_id),
    .resp_produto       (resp_produto),
    .mult_start         (mult_start),
    .mult_multiplicando (mult_multiplicando),
    .mult_multiplicador (mult_multiplicador),
    .mult_produto       (mult_produto),
    .ocupado            (ocupado)
`ifdef MBS_ESCALONADOR_STATS_EN
    ,
    .cont_ops           (cont_ops),
    .cont_bloqueio      (cont_bloqueio)
`endif
  );

  always #5 clock = ~clock;

  // mbs stand-in: garbage until LAT cycles after the start cycle, product from operands seen late.
  logic [7:0] m_cnt;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt        <= '0;
      mult_produto <= '0;
    end else if (mult_start) begin
      m_cnt        <= 8'(LAT - 1);
      mult_produto <= 16'hA5A5;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
      if (m_cnt == 1) mult_produto <= PW'(mult_multiplicando) * PW'(mult_multiplicador);
    end
  end

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    checks++;
    if (obs !== esp) begin
      erros++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, esp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) grants.push_back(i);
        verifica("grant_onehot", 64'($countones(req_ready)), 64'd1);
      end
      if (resp_valid && resp_ready) begin
        verifica("sb_nao_vazio", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          esp_r = sb.pop_front();
          verifica("resp_id", 64'(resp_id), 64'(esp_r.id));
          verifica("resp_produto", 64'(resp_produto), 64'(esp_r.prod));
        end
      end
    end
  end

  task automatic sobe();
    @(posedge clock);
    #1;
  endtask

  task automatic desce();
    @(negedge clock);
    #1;
  endtask

  task automatic reinicia();
    sobe();
    reset_n    = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    #2;
    sb.delete();
    grants.delete();
    repeat (2) sobe();
    reset_n = 1'b1;
  endtask

  task automatic pede(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit registra);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req_valid[id]    = 1'b1;
    if (registra) sb.push_back('{id: IDW'(id), prod: PW'(a) * PW'(b)});
  endtask

  task automatic espera_grants(input int n);
    int k = 0;
    while (grants.size() < n && k < 400) begin
      desce();
      k++;
    end
    verifica("timeout_grant", 64'(grants.size() >= n), 64'd1);
  endtask

  task automatic espera_vazio();
    int k = 0;
    while (sb.size() != 0 && k < 400) begin
      desce();
      k++;
    end
    verifica("timeout_resp", 64'(sb.size() == 0), 64'd1);
  endtask

  task automatic opera(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int n0;
    sobe();
    n0 = grants.size();
    pede(id, a, b, 1'b1);
    espera_grants(n0 + 1);
    sobe();
    req_valid[id] = 1'b0;
    espera_vazio();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kv;
    int ordem[5];
    logic [63:0] parado;
    ordem      = '{0, 1, 2, 3, 0};
    reset_n    = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    #12;
    verifica("reset_saidas", 64'({req_ready, resp_valid, mult_start, ocupado, resp_id,
                                  resp_produto, mult_multiplicando, mult_multiplicador}), 64'd0);
    sobe();
    reset_n = 1'b1;

    // 1: single request, exact latency
    sobe();
    req_a[0 +: W] = 8'd120;
    req_b[0 +: W] = 8'd96;
    req_valid[0]  = 1'b1;
    sb.push_back('{id: IDW'(0), prod: PW'(11520)});
    desce();
    verifica("t1_ready_c0", 64'(req_ready), 64'b0001);
    sobe();
    req_valid[0] = 1'b0;
    desce();
    verifica("t1_start_c1", 64'({mult_start, ocupado}), 64'b11);
    verifica("t1_operandos", 64'({mult_multiplicando, mult_multiplicador}), 64'h7860);
    kv = -1;
    for (int k = 2; k <= 30 && kv < 0; k++) begin
      desce();
      if (resp_valid) kv = k;
    end
    verifica("t1_latencia", 64'(kv), 64'(LAT + 3));
    espera_vazio();

    // 2: all requesters contend; round-robin order from reset
    reinicia();
    sobe();
    pede(0, 8'd3, 8'd7, 1'b1);
    pede(1, 8'd250, 8'd2, 1'b1);
    pede(2, 8'd17, 8'd19, 1'b1);
    pede(3, 8'd255, 8'd128, 1'b1);
    sb.push_back('{id: IDW'(0), prod: PW'(21)});
    espera_grants(5);
    sobe();
    req_valid = '0;
    espera_vazio();
    for (int i = 0; i < 5; i++) verifica("t2_ordem", 64'(grants[i]), 64'(ordem[i]));
`ifdef MBS_ESCALONADOR_STATS_EN
    verifica("t6_cont_ops", 64'(cont_ops), 64'd5);
    verifica("t6_cont_bloqueio", 64'(cont_bloqueio), 64'(4 * (LAT + 3)));
`endif

    // 3: consumer stalls in ENTREGA while another requester waits
    reinicia();
    sobe();
    resp_ready = 1'b0;
    pede(1, 8'd13, 8'd11, 1'b1);
    espera_grants(1);
    sobe();
    req_valid[1] = 1'b0;
    pede(3, 8'd9, 8'd9, 1'b1);
    kv = 0;
    while (!resp_valid && kv < 40) begin
      desce();
      kv++;
    end
    verifica("t3_resp_valid", 64'(resp_valid), 64'd1);
    parado = 64'({1'b1, 4'b0000, 1'b0, 1'b1, IDW'(1), PW'(143)});
    for (int k = 0; k < 20; k++) begin
      desce();
      verifica("t3_estagna", 64'({resp_valid, req_ready, mult_start, ocupado, resp_id,
                                  resp_produto}), parado);
    end
    sobe();
    resp_ready = 1'b1;
    espera_grants(2);
    sobe();
    req_valid[3] = 1'b0;
    espera_vazio();
    verifica("t3_segundo_grant", 64'(grants[1]), 64'd3);

    // 4: reset asserted mid-operation discards it; req2 is served afterwards
    reinicia();
    sobe();
    pede(0, 8'd77, 8'd3, 1'b0);
    espera_grants(1);
    sobe();
    req_valid[0] = 1'b0;
    pede(2, 8'd200, 8'd201, 1'b0);
    repeat (4) desce();
    verifica("t4_ocupado_antes", 64'(ocupado), 64'd1);
    reset_n = 1'b0;
    #1;
    verifica("t4_reset_saidas", 64'({req_ready, resp_valid, mult_start, ocupado, resp_id,
                                     resp_produto, mult_multiplicando, mult_multiplicador}), 64'd0);
    sobe();
    sobe();
    grants.delete();
    sb.delete();
    reset_n = 1'b1;
    sb.push_back('{id: IDW'(2), prod: PW'(40200)});
    espera_grants(1);
    verifica("t4_grant_req2", 64'(grants[0]), 64'd2);
    sobe();
    req_valid[2] = 1'b0;
    espera_vazio();

    // 5: edge operands
    reinicia();
    opera(2, 8'd255, 8'd255);
    opera(0, 8'd0, 8'd200);
    opera(3, 8'd1, 8'd255);
    verifica("t5_max", 64'(PW'(8'd255) * PW'(8'd255)), 64'h0000_FE01);

    desce();
    verifica("sb_final", 64'(sb.size()), 64'd0);
    verifica("ocioso_final", 64'({ocupado, resp_valid, req_ready}), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
